// File: rtl/cpu_stat_ctrl_if.sv
// Status/run handshake bundle between the Y86 commit stage and the run/stop controller.
// The slave modport is the controller's view; master is the core or testbench side.
interface cpu_stat_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [1:0]       stat_i;
    logic             commit_i;
    logic             clear_i;
    logic             run_o;
    logic [1:0]       cpu_stat_o;
    logic             done_o;
    logic [CNT_W-1:0] cycle_cnt_o;
    logic [CNT_W-1:0] instr_cnt_o;

    modport slave (
        input  stat_i,
        input  commit_i,
        input  clear_i,
        output run_o,
        output cpu_stat_o,
        output done_o,
        output cycle_cnt_o,
        output instr_cnt_o
    );

    modport master (
        output stat_i,
        output commit_i,
        output clear_i,
        input  run_o,
        input  cpu_stat_o,
        input  done_o,
        input  cycle_cnt_o,
        input  instr_cnt_o
    );
endinterface

// File: rtl/cpu_stat_ctrl.sv
// Y86 run/stop controller: latches the first non-AOK commit status, drives the global
// run enable, and keeps saturating cycle and retired-instruction counters.
module cpu_stat_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    cpu_stat_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_START = 2'b00,
        ST_RUN   = 2'b01,
        ST_STOP  = 2'b10
    } state_e;

    localparam logic [1:0]       STAT_AOK = 2'b00;
    localparam logic [1:0]       STAT_HLT = 2'b01;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    state_e           state_q, state_d;
    logic [1:0]       cpu_stat_q, cpu_stat_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    // Next-state, status latch and counter update logic
    always_comb begin
        state_d     = state_q;
        cpu_stat_d  = cpu_stat_q;
        done_d      = 1'b0;
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        case (state_q)
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cycle_cnt_d = sat_inc(cycle_cnt_q);
                // HLT retires its instruction; ADR/INS faults do not.
                if (bus.commit_i && ((bus.stat_i == STAT_AOK) || (bus.stat_i == STAT_HLT))) begin
                    instr_cnt_d = sat_inc(instr_cnt_q);
                end else begin
                    instr_cnt_d = instr_cnt_q;
                end
                if (bus.commit_i && (bus.stat_i != STAT_AOK)) begin
                    state_d    = ST_STOP;
                    cpu_stat_d = bus.stat_i;
                    done_d     = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STOP: begin
                if (bus.clear_i) begin
                    state_d     = ST_START;
                    cpu_stat_d  = STAT_AOK;
                    cycle_cnt_d = CNT_ZERO;
                    instr_cnt_d = CNT_ZERO;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_START;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_START;
            cpu_stat_q  <= STAT_AOK;
            done_q      <= 1'b0;
            cycle_cnt_q <= CNT_ZERO;
            instr_cnt_q <= CNT_ZERO;
        end else begin
            state_q     <= state_d;
            cpu_stat_q  <= cpu_stat_d;
            done_q      <= done_d;
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign bus.run_o       = (state_q == ST_RUN);
    assign bus.cpu_stat_o  = cpu_stat_q;
    assign bus.done_o      = done_q;
    assign bus.cycle_cnt_o = cycle_cnt_q;
    assign bus.instr_cnt_o = instr_cnt_q;
endmodule
